serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 1, meaning bits added per cycle; WIDTH mod CHUNK SHALL be 0; N = WIDTH/CHUNK.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  operands valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B.
REQ-010 cin  input  1  carry-in.
REQ-011 sub  input  1  1 = compute A - B (- cin ignored, see REQ-017), 0 = A + B + cin.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 sum  output  WIDTH  result.
REQ-015 cout  output  1  final carry out of MSB.
REQ-016 ovf  output  1  signed two's-complement overflow.

Function
REQ-017 Operation: add: sum = A + B + cin; sub: sum = A + ~B + 1 (cin ignored); cout = carry out of bit WIDTH-1 (sub: cout = 1 means no borrow).
REQ-018 FSM states SHALL be IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-019 IDLE: on in_valid && in_ready, SHALL latch a, b XOR {WIDTH{sub}}, carry = sub ? 1 : cin, chunk index = 0, go to RUN; otherwise stay IDLE.
REQ-020 RUN: each cycle SHALL add chunk[idx] of latched A, latched B and carry register, write CHUNK sum bits into sum[idx*CHUNK +: CHUNK], update carry, increment idx.
REQ-021 RUN: on the cycle idx = N-1, SHALL also record the carry into the MSB for ovf and go to DONE.
REQ-022 Latency: handshake at edge k -> out_valid high after edge k+N+1... precisely: RUN occupies edges k+1..k+N, out_valid observed high from edge k+N onward.
REQ-023 DONE: sum, cout, ovf SHALL be held stable while out_valid = 1 && out_ready = 0.
REQ-024 DONE: on out_ready = 1, SHALL go to IDLE at that edge; in_ready high the following cycle (no same-cycle accept in DONE).
REQ-025 ovf SHALL equal carry-into-MSB XOR cout.
REQ-026 Inputs a, b, cin, sub, in_valid SHALL be ignored outside IDLE; changing them mid-operation SHALL NOT affect the result.
REQ-027 out_ready SHALL be ignored outside DONE.
REQ-028 CHUNK = WIDTH (N = 1) SHALL be legal: one RUN cycle.
REQ-029 Wrap-around: result SHALL be modulo 2^WIDTH; no saturation.

Reset
REQ-030 rst = 1 SHALL force state IDLE, in_ready = 1 after the edge, out_valid = 0, sum = 0, cout = 0, ovf = 0, carry and idx = 0.
REQ-031 rst SHALL take priority over any handshake in the same cycle; reset during RUN or DONE SHALL abort the operation with no result delivered.

Verification
REQ-032 WIDTH=8, CHUNK=1: a=0x0F, b=0x01, cin=0, sub=0 -> after 8 RUN cycles sum=0x10, cout=0, ovf=0, out_valid at edge k+8.
REQ-033 WIDTH=8, CHUNK=1: a=0xFF, b=0x01, cin=1, sub=0 -> sum=0x01, cout=1, ovf=0.
REQ-034 WIDTH=8, CHUNK=4: a=0x7F, b=0x01, sub=0 -> sum=0x80, cout=0, ovf=1, out_valid at edge k+2.
REQ-035 WIDTH=8, CHUNK=1: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1.
REQ-036 Backpressure: hold out_ready=0 for 5 cycles in DONE with a, b toggling -> sum/cout/ovf unchanged, in_ready=0; then out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-037 Reset mid-RUN at idx=3 -> next cycle IDLE, out_valid=0, all outputs 0; a new operation afterwards completes correctly.

Source files
------------

// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per cycle over WIDTH/CHUNK cycles,
// with a valid/ready handshake on both the operand side and the result side.
`timescale 1ns/1ps

module serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic             carry_into_msb;

    // One slice of the datapath; in the final chunk its top bit is the operand MSB.
    always_comb begin
        a_chunk        = a_q[idx_q*CHUNK +: CHUNK];
        b_chunk        = b_q[idx_q*CHUNK +: CHUNK];
        chunk_sum      = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK + 1)'(carry_q);
        carry_into_msb = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_sum[CHUNK-1];
    end

    always_comb begin
        // NOTE: every *_d gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b ^ {WIDTH{sub}};
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[idx_q*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d = chunk_sum[CHUNK];
                if (idx_q == LAST_IDX) begin
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = carry_into_msb ^ chunk_sum[CHUNK];
                    idx_d   = '0;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DONE: begin
                // Results stay in their registers until the consumer takes them.
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule
